// File: rtl/cordic_post_stage.sv
// Output stage of a CORDIC rotator: gain compensation, round-half-to-even,
// symmetric saturation, valid tracking and sticky overflow/saturation counting.
module cordic_post_stage #(
  parameter int WW      = 16,
  parameter int OW      = 12,
  parameter int NSTAGES = 13,
  parameter int GAIN    = 79594
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_ce,
  input  logic                 i_valid,
  input  logic signed [WW-1:0] x_in,
  input  logic signed [WW-1:0] y_in,
  input  logic                 i_clr_ovf,
  output logic signed [OW-1:0] o_x,
  output logic signed [OW-1:0] o_y,
  output logic                 o_valid,
  output logic                 o_ovf,
  output logic [15:0]          o_sat_cnt
);

  localparam int PW   = WW + 19;        // product width
  localparam int D    = 17 + WW - OW;   // LSBs dropped by rounding
  localparam int RW   = PW - D + 1;     // rounded width, one guard bit for the +1
  localparam int MAXV = 2**(OW-1) - 1;

  localparam logic [D-1:0]         HALF   = {1'b1, {(D-1){1'b0}}};
  localparam logic signed [RW-1:0] SAT_HI = RW'(MAXV);
  localparam logic signed [RW-1:0] SAT_LO = -SAT_HI;
  localparam logic signed [OW-1:0] OUT_HI = OW'(MAXV);
  localparam logic signed [OW-1:0] OUT_LO = -OUT_HI;

  typedef struct packed {
    logic signed [OW-1:0] val;
    logic                 sat;
  } sat_t;

  function automatic logic signed [RW-1:0] round_even(input logic signed [PW-1:0] p);
    logic signed [RW-2:0] trunc;
    logic [D-1:0]         frac;
    logic                 up;
    trunc = p[PW-1:D];
    frac  = p[D-1:0];
    up    = (frac > HALF) || ((frac == HALF) && trunc[0]);
    return {trunc[RW-2], trunc} + RW'(up);
  endfunction

  function automatic sat_t saturate(input logic signed [RW-1:0] v);
    sat_t s;
    s.sat = 1'b1;
    if (v > SAT_HI) begin
      s.val = OUT_HI;
    end else if (v < SAT_LO) begin
      s.val = OUT_LO;
    end else begin
      s.val = v[OW-1:0];
      s.sat = 1'b0;
    end
    return s;
  endfunction

  // Valid tracker runs alongside the upstream rotation stages.
  logic [NSTAGES-1:0] r_vtrack;
  logic [NSTAGES-1:0] w_vtrack_next;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_vtrack_next    = r_vtrack << 1;
    w_vtrack_next[0] = i_valid;
  end

  // Stage A: gain multiply. GAIN is forced non-negative by zero extension.
  logic signed [PW-1:0] w_x_ext, w_y_ext, w_gain_ext, w_px, w_py;
  logic signed [PW-1:0] r_px, r_py;
  logic                 r_a_valid;

  assign w_x_ext    = {{19{x_in[WW-1]}}, x_in};
  assign w_y_ext    = {{19{y_in[WW-1]}}, y_in};
  assign w_gain_ext = {{WW{1'b0}}, 1'b0, 18'(GAIN)};
  assign w_px       = w_x_ext * w_gain_ext;
  assign w_py       = w_y_ext * w_gain_ext;

  // NOTE: datapath registers are reset too so in-flight samples vanish on reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_vtrack  <= '0;
      r_px      <= '0;
      r_py      <= '0;
      r_a_valid <= 1'b0;
    end else if (i_ce) begin
      r_vtrack  <= w_vtrack_next;
      r_px      <= w_px;
      r_py      <= w_py;
      r_a_valid <= r_vtrack[NSTAGES-1];
    end
  end

  // Stage B: round, saturate and register outputs.
  sat_t w_sx, w_sy;
  assign w_sx = saturate(round_even(r_px));
  assign w_sy = saturate(round_even(r_py));

  logic signed [OW-1:0] r_ox, r_oy;
  logic                 r_ovalid;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ox     <= '0;
      r_oy     <= '0;
      r_ovalid <= 1'b0;
    end else if (i_ce) begin
      r_ox     <= w_sx.val;
      r_oy     <= w_sy.val;
      r_ovalid <= r_a_valid;
    end
  end

  // Flag and counter: clear acts without i_ce; same-edge saturation overrides it.
  logic        w_set;
  logic [1:0]  w_inc;
  logic [16:0] w_cnt_sum;
  logic [15:0] w_cnt_next;
  logic        r_ovf;
  logic [15:0] r_sat_cnt;

  assign w_set      = i_ce && r_a_valid && (w_sx.sat || w_sy.sat);
  assign w_inc      = (i_ce && r_a_valid) ? ({1'b0, w_sx.sat} + {1'b0, w_sy.sat}) : 2'd0;
  assign w_cnt_sum  = {1'b0, (i_clr_ovf ? 16'd0 : r_sat_cnt)} + {15'd0, w_inc};
  assign w_cnt_next = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ovf     <= 1'b0;
      r_sat_cnt <= '0;
    end else begin
      if (w_set)          r_ovf <= 1'b1;
      else if (i_clr_ovf) r_ovf <= 1'b0;
      r_sat_cnt <= w_cnt_next;
    end
  end

  assign o_x       = r_ox;
  assign o_y       = r_oy;
  assign o_valid   = r_ovalid;
  assign o_ovf     = r_ovf;
  assign o_sat_cnt = r_sat_cnt;

endmodule

// File: tb/tb_cordic_post_stage.sv
// Directed bench for cordic_post_stage: three instances (default, unity and
// near-2x gain) share one stimulus stream; expected values are hand-derived or modelled.
module tb_cordic_post_stage;

  localparam int D = 21;

  logic               i_clk = 1'b0;
  logic               i_reset_n, i_ce, i_valid, i_clr_ovf;
  logic signed [15:0] x_in, y_in;

  logic signed [11:0] d_x, d_y, r_x, r_y, s_x, s_y;
  logic               d_valid, d_ovf, r_valid, r_ovf, s_valid, s_ovf;
  logic [15:0]        d_cnt, r_cnt, s_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 i_clk = ~i_clk;

  cordic_post_stage u_dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(i_ce), .i_valid(i_valid),
    .x_in(x_in), .y_in(y_in), .i_clr_ovf(i_clr_ovf),
    .o_x(d_x), .o_y(d_y), .o_valid(d_valid), .o_ovf(d_ovf), .o_sat_cnt(d_cnt)
  );

  cordic_post_stage #(.GAIN(131072)) u_rnd (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(i_ce), .i_valid(i_valid),
    .x_in(x_in), .y_in(y_in), .i_clr_ovf(i_clr_ovf),
    .o_x(r_x), .o_y(r_y), .o_valid(r_valid), .o_ovf(r_ovf), .o_sat_cnt(r_cnt)
  );

  cordic_post_stage #(.GAIN(262143)) u_sat (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(i_ce), .i_valid(i_valid),
    .x_in(x_in), .y_in(y_in), .i_clr_ovf(i_clr_ovf),
    .o_x(s_x), .o_y(s_y), .o_valid(s_valid), .o_ovf(s_ovf), .o_sat_cnt(s_cnt)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Reference: exact product, floor divide by 2^D, ties to even, clamp to +-2047.
  function automatic int model(input int v, input longint g);
    longint p, q, r;
    p = longint'(v) * g;
    q = p >>> D;
    r = p - q * (longint'(1) << D);
    if (r > (longint'(1) << (D-1)) || (r == (longint'(1) << (D-1)) && q[0])) q++;
    if (q > 2047)  q = 2047;
    if (q < -2047) q = -2047;
    return int'(q);
  endfunction

  int xs[5]   = '{24, 40, -24, -40, 25};
  int xexp[5] = '{2, 2, -2, -2, 2};
  int sx[120], sy[120];

  initial begin
    i_reset_n = 1'b0; i_ce = 1'b1; i_valid = 1'b0; i_clr_ovf = 1'b0;
    x_in = '0; y_in = '0;

    // Reset state
    tick();
    check("rst_o_x", d_x, 0);
    check("rst_o_valid", d_valid, 0);
    check("rst_o_ovf", s_ovf, 0);
    check("rst_sat_cnt", s_cnt, 0);
    @(negedge i_clk);
    i_reset_n = 1'b1;

    // Nominal: valid pulse, x held at full scale; o_valid on edge NSTAGES+2
    x_in = 16'sd32767; y_in = 16'sd0; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    check("nom_valid_e1", d_valid, 0);
    for (int n = 2; n <= 16; n++) begin
      tick();
      check($sformatf("nom_valid_e%0d", n), d_valid, (n == 15));
      if (n == 15) begin
        check("nom_o_x", d_x, 1244);
        check("nom_o_y", d_y, 0);
      end
    end
    check("nom_gain2_cnt", s_cnt, 1);
    check("nom_gain2_ovf", s_ovf, 1);

    // Rounding with unity gain: x/16, ties to even
    for (int i = 0; i < 5; i++) begin
      x_in = 16'(xs[i]);
      tick();
      tick();
      check($sformatf("rnd_x_%0d", xs[i]), r_x, xexp[i]);
    end
    check("rnd_y", r_y, 0);

    // Saturation then clear with i_ce=0
    i_clr_ovf = 1'b1; i_valid = 1'b1;
    x_in = 16'sd32767; y_in = -16'sd32768;
    tick();
    i_clr_ovf = 1'b0; i_valid = 1'b0;
    check("sat_clr_ovf", s_ovf, 0);
    check("sat_clr_cnt", s_cnt, 0);
    repeat (14) tick();
    check("sat_valid", s_valid, 1);
    check("sat_o_x", s_x, 2047);
    check("sat_o_y", s_y, -2047);
    check("sat_ovf", s_ovf, 1);
    check("sat_cnt", s_cnt, 2);
    i_ce = 1'b0; i_clr_ovf = 1'b1;
    tick();
    i_ce = 1'b1; i_clr_ovf = 1'b0;
    check("clr_noce_ovf", s_ovf, 0);
    check("clr_noce_cnt", s_cnt, 0);
    check("clr_noce_hold_x", s_x, 2047);

    // Flush tracker
    i_valid = 1'b0;
    repeat (20) tick();

    // Stall: random i_ce over a 100-sample stream
    for (int k = 0; k < 120; k++) begin
      sx[k] = int'($urandom_range(0, 65535)) - 32768;
      sy[k] = int'($urandom_range(0, 65535)) - 32768;
    end
    begin
      int  k = 0;
      int  seen = 0;
      int  iter = 0;
      bit  known = 0;
      bit  ce;
      bit  ev = 0;
      int  ex = 0, ey = 0;
      while (k < 120 && iter < 1000) begin
        iter++;
        ce = ($urandom_range(0, 2) != 0);
        i_ce = ce;
        if (ce) begin
          x_in = 16'(sx[k]); y_in = 16'(sy[k]); i_valid = (k < 100);
        end else begin
          x_in = 16'($urandom); y_in = 16'($urandom); i_valid = 1'b1;
        end
        tick();
        if (ce) begin
          if (k >= 1) begin
            known = 1;
            ev = (k - 1 >= 13) && (k - 1 < 113);
            ex = model(sx[k-1], 79594);
            ey = model(sy[k-1], 79594);
          end
          if (d_valid) seen++;
          k++;
        end
        if (known) begin
          check("stall_valid", d_valid, ev);
          if (ev) begin
            check("stall_o_x", d_x, ex);
            check("stall_o_y", d_y, ey);
          end
        end
      end
      check("stall_budget", (k == 120), 1);
      check("stall_sample_count", seen, 100);
    end
    i_ce = 1'b1; i_valid = 1'b0;

    // Reset mid-flight with 5 samples in the tracker
    x_in = 16'sd20000; y_in = -16'sd20000; i_valid = 1'b1;
    repeat (5) tick();
    i_valid = 1'b0;
    repeat (3) tick();
    check("pre_rst_o_x", d_x, 759);
    #2 i_reset_n = 1'b0;
    #1;
    check("async_rst_o_x", d_x, 0);
    check("async_rst_o_y", d_y, 0);
    check("async_rst_valid", d_valid, 0);
    check("async_rst_cnt", s_cnt, 0);
    check("async_rst_ovf", s_ovf, 0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      check($sformatf("post_rst_valid_%0d", n), d_valid, 0);
      if (n == 2) check("post_rst_o_x", d_x, 759);
    end

    // Counter ceiling: both components saturate on every valid sample
    i_clr_ovf = 1'b1;
    tick();
    i_clr_ovf = 1'b0;
    x_in = 16'sd32767; y_in = -16'sd32768; i_valid = 1'b1;
    for (int n = 1; n <= 40000; n++) begin
      tick();
      if (n == 114) check("ceil_cnt_mid", s_cnt, 200);
    end
    check("ceil_cnt", s_cnt, 65535);
    check("ceil_ovf", s_ovf, 1);
    repeat (10) tick();
    check("ceil_cnt_held", s_cnt, 65535);
    i_clr_ovf = 1'b1;
    tick();
    i_clr_ovf = 1'b0;
    check("clr_vs_set_ovf", s_ovf, 1);
    check("clr_then_inc_cnt", s_cnt, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
